// File: rtl/musa_defs.sv
// ---------------------------------------------------------------------------
// musa_defs
//   Shared definitions for the call/return stack beside the register file.
//   - DATA_W_DEF / DEPTH_DEF : default entry width and stack depth
//   - stack_op_t             : operation decoded from {push, pop}
// ---------------------------------------------------------------------------
package musa_defs;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    // Operation formed as {push, pop}.
    typedef enum logic [1:0] {
        NOP  = 2'b00,
        POP  = 2'b01,
        PUSH = 2'b10,
        XCHG = 2'b11
    } stack_op_t;

endpackage

// File: rtl/stack_ram.sv
// ---------------------------------------------------------------------------
// stack_ram
//   DEPTH x DATA_W storage for call_stack. One synchronous write port and one
//   asynchronous read port. The owner computes all addresses. Contents are
//   not reset.
//   Ports:
//     clk    in  rising-edge clock
//     we     in  write enable
//     waddr  in  write address
//     wdata  in  write data
//     raddr  in  read address
//     rdata  out read data (combinational from raddr)
// ---------------------------------------------------------------------------
module stack_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// ---------------------------------------------------------------------------
// call_stack
//   Hardware LIFO answering the decode stage's push/pop requests. A push
//   stores a return word; a pop delivers the top word one cycle later.
//   Ports:
//     clk        in  rising-edge clock
//     rst        in  asynchronous, active-low reset
//     push/pop   in  requests sampled at posedge clk
//     push_data  in  word to push
//     err_clr    in  clears sticky overflow/underflow
//     pop_data   out popped word (registered, holds when pop_valid=0)
//     pop_valid  out one-cycle pulse per accepted pop
//     count      out occupancy 0..DEPTH
//     empty/full out decoded from count
//     overflow   out sticky: push while full
//     underflow  out sticky: pop while empty
//   Build option:
//     STACK_WRAP_EN : circular storage; push while full overwrites the oldest
//                     entry (overflow still flags it). Undefined: word dropped.
// ---------------------------------------------------------------------------
module call_stack
    import musa_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);

`ifdef STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // sp is kept modulo DEPTH (DEPTH is a power of two). Without wrap it only
    // reaches 0 again when count==DEPTH, where further pushes are dropped, so
    // the same pointer serves both modes.
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  top_addr;
    logic [PTR_W-1:0]  waddr;
    logic              we;
    logic [DATA_W-1:0] top_data;
    stack_op_t         op;

    assign op       = stack_op_t'({push, pop});
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign top_addr = sp - PTR_W'(1);

    // RAM write: a push goes to the free slot at sp; an exchange replaces the
    // current top in place. The read port always presents the current top,
    // so an exchange captures the old top before the write lands.
    always_comb begin
        we    = 1'b0;
        waddr = sp;
        case (op)
            PUSH: we = !full || WRAP;
            XCHG: begin
                we    = !empty;
                waddr = top_addr;
            end
            default: we = 1'b0;
        endcase
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (top_addr),
        .rdata (top_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp        <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            // Clear first so a new error in the same cycle takes priority.
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (op)
                PUSH: begin
                    if (!full) begin
                        sp    <= sp + PTR_W'(1);
                        count <= count + CNT_W'(1);
                    end else begin
                        overflow <= 1'b1;
                        if (WRAP) begin
                            sp <= sp + PTR_W'(1);
                        end
                    end
                end
                POP: begin
                    if (!empty) begin
                        pop_data  <= top_data;
                        pop_valid <= 1'b1;
                        sp        <= top_addr;
                        count     <= count - CNT_W'(1);
                    end else begin
                        underflow <= 1'b1;
                    end
                end
                XCHG: begin
                    // Empty stack: the pushed word bypasses straight out.
                    pop_data  <= empty ? push_data : top_data;
                    pop_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
